// File: rtl/imem_program_loader_if.sv
// Host-side instruction stream plus instruction-memory write port and
// loader status, bundled for the program loader.
interface imem_program_loader_if #(
    parameter int ADDR_W = 6
);
    // Host instruction stream
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              restart;

    // Instruction-memory write port
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Load status
    logic [ADDR_W:0]   words_loaded;
    logic              load_done;
    logic              full;
    logic              err;
    logic              cpu_rst_n;

    // Loader side
    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm,
               in_target, in_last, restart,
        output in_ready, imem_we, imem_addr, imem_wdata, words_loaded,
               load_done, full, err, cpu_rst_n
    );

    // Host side
    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm,
               in_target, in_last, restart,
        input  in_ready, imem_we, imem_addr, imem_wdata, words_loaded,
               load_done, full, err, cpu_rst_n
    );
endinterface

// File: rtl/imem_program_loader.sv
// Program loader: encodes symbolic MIPS instructions from a host into
// machine words, writes them sequentially into instruction memory from
// address 0, and holds the processor in reset until the load completes.
module imem_program_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_program_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WORD_ONE  = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
    logic              load_done_q, load_done_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              last_q, last_d;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              transfer;

    // Encode the presented instruction; opcodes 10-15 are flagged illegal
    always_comb begin
        enc_word  = 32'd0;
        enc_legal = 1'b1;
        unique case (bus.in_op)
            4'd0: enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, bus.in_funct};
            4'd1: enc_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd2: enc_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd3: enc_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd4: enc_word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd5: enc_word = {6'b001100, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd6: enc_word = {6'b000010, bus.in_target};
            4'd7: enc_word = {6'b001101, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd8: enc_word = {6'b001111, 5'b00000, bus.in_rt, bus.in_imm};
            4'd9: enc_word = {6'b001001, bus.in_rs, bus.in_rt, bus.in_imm};
            default: enc_legal = 1'b0;
        endcase
    end

    assign transfer = bus.in_valid && (state_q == S_IDLE);

    // Next-state and registered-output logic; restart overrides every state
    always_comb begin
        state_d        = state_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        words_loaded_d = words_loaded_q;
        load_done_d    = load_done_q;
        full_d         = full_q;
        err_d          = err_q;
        cpu_rst_n_d    = cpu_rst_n_q;
        last_d         = last_q;

        if (bus.restart) begin
            // A write already on the bus this cycle still completes, since
            // imem_we_q is high for the whole WRITE cycle.
            state_d        = S_IDLE;
            imem_addr_d    = '0;
            words_loaded_d = '0;
            load_done_d    = 1'b0;
            full_d         = 1'b0;
            err_d          = 1'b0;
            cpu_rst_n_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (transfer) begin
                        if (enc_legal) begin
                            imem_wdata_d = enc_word;
                            last_d       = bus.in_last;
                            imem_we_d    = 1'b1;
                            state_d      = S_WRITE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end
                    end
                end
                S_WRITE: begin
                    words_loaded_d = words_loaded_q + WORD_ONE;
                    if (last_q) begin
                        load_done_d = 1'b1;
                        cpu_rst_n_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (imem_addr_q == LAST_ADDR) begin
                        // Memory is full: stop here rather than wrap.
                        full_d      = 1'b1;
                        load_done_d = 1'b1;
                        cpu_rst_n_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        imem_addr_d = imem_addr_q + ADDR_ONE;
                        state_d     = S_IDLE;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            words_loaded_q <= '0;
            load_done_q    <= 1'b0;
            full_q         <= 1'b0;
            err_q          <= 1'b0;
            cpu_rst_n_q    <= 1'b0;
            last_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            words_loaded_q <= words_loaded_d;
            load_done_q    <= load_done_d;
            full_q         <= full_d;
            err_q          <= err_d;
            cpu_rst_n_q    <= cpu_rst_n_d;
            last_q         <= last_d;
        end
    end

    assign bus.in_ready     = (state_q == S_IDLE);
    assign bus.imem_we      = imem_we_q;
    assign bus.imem_addr    = imem_addr_q;
    assign bus.imem_wdata   = imem_wdata_q;
    assign bus.words_loaded = words_loaded_q;
    assign bus.load_done    = load_done_q;
    assign bus.full         = full_q;
    assign bus.err          = err_q;
    assign bus.cpu_rst_n    = cpu_rst_n_q;
endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for the program loader: encoding table, back-to-back
// stream, full memory (DEPTH=4 instance), illegal op, restart and reset.
module tb_imem_program_loader;
    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic        last;
        logic [31:0] exp_word;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    imem_program_loader_if #(.ADDR_W(6)) bus  ();
    imem_program_loader_if #(.ADDR_W(6)) bus4 ();

    imem_program_loader #(.ADDR_W(6), .DEPTH(64)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    imem_program_loader #(.ADDR_W(6), .DEPTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [15:0] imm, input logic last, input logic [31:0] w);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.rd = 5'd0; v.funct = 6'd0;
        v.imm = imm; v.target = 26'd0; v.last = last; v.exp_word = w;
        return v;
    endfunction

    // Present one instruction on the main loader once it is ready; returns
    // one cycle after the transfer edge (the WRITE cycle for a legal op).
    task automatic send(input vec_t v);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_op = v.op; bus.in_rs = v.rs; bus.in_rt = v.rt; bus.in_rd = v.rd;
        bus.in_funct = v.funct; bus.in_imm = v.imm; bus.in_target = v.target;
        bus.in_last = v.last;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
    endtask

    vec_t tbl [10];

    initial begin
        int we_cnt;
        n_vec = 0;
        n_miss = 0;

        // Encoding table: unused fields carry junk to prove they are ignored
        tbl[0] = '{4'd1, 5'd29, 5'd8,  5'd3,  6'h3F, 16'h0004, 26'h3FFFFFF, 1'b0, 32'h8FA80004}; // lw
        tbl[1] = '{4'd0, 5'd8,  5'd9,  5'd10, 6'h20, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h01095020}; // add
        tbl[2] = '{4'd8, 5'd31, 5'd1,  5'd7,  6'h11, 16'h1001, 26'h1234567, 1'b0, 32'h3C011001}; // lui
        tbl[3] = '{4'd2, 5'd29, 5'd31, 5'd0,  6'h00, 16'hFFFC, 26'h0000000, 1'b0, 32'hAFBFFFFC}; // sw
        tbl[4] = '{4'd3, 5'd1,  5'd2,  5'd0,  6'h00, 16'hFFFF, 26'h0000000, 1'b0, 32'h1022FFFF}; // beq
        tbl[5] = '{4'd4, 5'd0,  5'd5,  5'd0,  6'h00, 16'h7FFF, 26'h0000000, 1'b0, 32'h20057FFF}; // addi
        tbl[6] = '{4'd5, 5'd3,  5'd4,  5'd0,  6'h00, 16'h00FF, 26'h0000000, 1'b0, 32'h306400FF}; // andi
        tbl[7] = '{4'd7, 5'd4,  5'd4,  5'd0,  6'h00, 16'h1234, 26'h0000000, 1'b0, 32'h34841234}; // ori
        tbl[8] = '{4'd9, 5'd29, 5'd29, 5'd0,  6'h00, 16'hFFF8, 26'h0000000, 1'b0, 32'h27BDFFF8}; // addiu
        tbl[9] = '{4'd6, 5'd5,  5'd6,  5'd7,  6'h2A, 16'hABCD, 26'h0000010, 1'b1, 32'h08000010}; // j

        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
        bus.in_funct = '0; bus.in_imm = '0; bus.in_target = '0; bus.in_last = 1'b0; bus.restart = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_op = '0; bus4.in_rs = '0; bus4.in_rt = '0; bus4.in_rd = '0;
        bus4.in_funct = '0; bus4.in_imm = '0; bus4.in_target = '0; bus4.in_last = 1'b0; bus4.restart = 1'b0;

        // ---- Reset, then idle for 10 cycles ----
        rst_n = 1'b0;
        #23;
        rst_n = 1'b1;
        tick();
        check("rst_in_ready",  32'(bus.in_ready), 32'd1);
        check("rst_we",        32'(bus.imem_we), 32'd0);
        check("rst_addr",      32'(bus.imem_addr), 32'd0);
        check("rst_wdata",     bus.imem_wdata, 32'd0);
        check("rst_words",     32'(bus.words_loaded), 32'd0);
        check("rst_done",      32'(bus.load_done), 32'd0);
        check("rst_full",      32'(bus.full), 32'd0);
        check("rst_err",       32'(bus.err), 32'd0);
        check("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
        we_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.imem_we) we_cnt++;
            tick();
        end
        check("idle_no_we", 32'(we_cnt), 32'd0);

        // ---- Encoding table ----
        for (int i = 0; i < 10; i++) begin
            send(tbl[i]);
            check("enc_we",    32'(bus.imem_we), 32'd1);
            check("enc_addr",  32'(bus.imem_addr), 32'(i));
            check("enc_wdata", bus.imem_wdata, tbl[i].exp_word);
            check("enc_ready_write", 32'(bus.in_ready), 32'd0);
            tick();
            check("enc_we_drop", 32'(bus.imem_we), 32'd0);
            check("enc_words",   32'(bus.words_loaded), 32'(i + 1));
            if (tbl[i].last) begin
                check("enc_done",      32'(bus.load_done), 32'd1);
                check("enc_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
                check("enc_ready_done", 32'(bus.in_ready), 32'd0);
                check("enc_addr_hold", 32'(bus.imem_addr), 32'(i));
                check("enc_full",      32'(bus.full), 32'd0);
            end else begin
                check("enc_ready_idle", 32'(bus.in_ready), 32'd1);
                check("enc_not_done",   32'(bus.load_done), 32'd0);
                check("enc_cpu_held",   32'(bus.cpu_rst_n), 32'd0);
            end
        end

        // ---- Restart, then back-to-back stream with in_valid held ----
        do_restart();
        check("rs_ready", 32'(bus.in_ready), 32'd1);
        check("rs_addr",  32'(bus.imem_addr), 32'd0);
        check("rs_words", 32'(bus.words_loaded), 32'd0);
        check("rs_done",  32'(bus.load_done), 32'd0);
        check("rs_cpu",   32'(bus.cpu_rst_n), 32'd0);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.in_op = 4'd4; bus.in_rs = 5'd0; bus.in_rt = 5'(k);
            bus.in_imm = 16'(k); bus.in_last = (k == 4);
            check("b2b_ready", 32'(bus.in_ready), 32'd1);
            tick();
            check("b2b_we",    32'(bus.imem_we), 32'd1);
            check("b2b_addr",  32'(bus.imem_addr), 32'(k));
            check("b2b_wdata", bus.imem_wdata, {6'b001000, 5'd0, 5'(k), 16'(k)});
            check("b2b_ready_low", 32'(bus.in_ready), 32'd0);
            tick();
            check("b2b_we_gap", 32'(bus.imem_we), 32'd0);
        end
        check("b2b_done",  32'(bus.load_done), 32'd1);
        check("b2b_words", 32'(bus.words_loaded), 32'd5);
        we_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.imem_we) we_cnt++;
        end
        check("b2b_no_extra_we", 32'(we_cnt), 32'd0);
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;

        // ---- Illegal op after two words ----
        do_restart();
        send(mk(4'd1, 5'd1, 5'd2, 16'h0010, 1'b0, 32'h8C220010));
        check("ill_w0", bus.imem_wdata, 32'h8C220010);
        tick();
        send(mk(4'd2, 5'd3, 5'd4, 16'h0020, 1'b0, 32'hAC640020));
        check("ill_w1", bus.imem_wdata, 32'hAC640020);
        tick();
        send(mk(4'd12, 5'd1, 5'd1, 16'h0001, 1'b0, 32'h0));
        check("ill_err",   32'(bus.err), 32'd1);
        check("ill_no_we", 32'(bus.imem_we), 32'd0);
        check("ill_ready", 32'(bus.in_ready), 32'd0);
        we_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.imem_we) we_cnt++;
            tick();
        end
        check("ill_no_write", 32'(we_cnt), 32'd0);
        check("ill_words",    32'(bus.words_loaded), 32'd2);
        check("ill_cpu",      32'(bus.cpu_rst_n), 32'd0);
        check("ill_sticky",   32'(bus.err), 32'd1);

        // ---- Recovery via restart ----
        do_restart();
        check("rec_err",   32'(bus.err), 32'd0);
        check("rec_addr",  32'(bus.imem_addr), 32'd0);
        check("rec_ready", 32'(bus.in_ready), 32'd1);
        check("rec_words", 32'(bus.words_loaded), 32'd0);

        // ---- Full on the DEPTH=4 loader ----
        for (int i = 0; i < 4; i++) begin
            bus4.in_op = 4'd4; bus4.in_rs = 5'd2; bus4.in_rt = 5'(i);
            bus4.in_imm = 16'(i + 16'h100); bus4.in_last = 1'b0;
            check("full_ready", 32'(bus4.in_ready), 32'd1);
            bus4.in_valid = 1'b1;
            tick();
            bus4.in_valid = 1'b0;
            check("full_we",    32'(bus4.imem_we), 32'd1);
            check("full_addr",  32'(bus4.imem_addr), 32'(i));
            check("full_wdata", bus4.imem_wdata, {6'b001000, 5'd2, 5'(i), 16'(i + 16'h100)});
            tick();
            if (i < 3) check("full_early", 32'(bus4.full), 32'd0);
        end
        check("full_flag",  32'(bus4.full), 32'd1);
        check("full_done",  32'(bus4.load_done), 32'd1);
        check("full_cpu",   32'(bus4.cpu_rst_n), 32'd1);
        check("full_words", 32'(bus4.words_loaded), 32'd4);
        check("full_addr_hold", 32'(bus4.imem_addr), 32'd3);
        bus4.in_valid = 1'b1;
        bus4.in_rt = 5'd4;
        we_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus4.in_ready) we_cnt++;
            tick();
            if (bus4.imem_we) we_cnt++;
        end
        bus4.in_valid = 1'b0;
        check("full_fifth_rejected", 32'(we_cnt), 32'd0);
        check("full_words_final",    32'(bus4.words_loaded), 32'd4);

        // ---- Asynchronous reset in the middle of a WRITE cycle ----
        send(mk(4'd5, 5'd7, 5'd8, 16'h00F0, 1'b0, 32'h30E800F0));
        check("ar_we_before", 32'(bus.imem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_we",    32'(bus.imem_we), 32'd0);
        check("ar_wdata", bus.imem_wdata, 32'd0);
        check("ar_addr",  32'(bus.imem_addr), 32'd0);
        check("ar_words", 32'(bus.words_loaded), 32'd0);
        check("ar_ready", 32'(bus.in_ready), 32'd1);
        check("ar_cpu",   32'(bus.cpu_rst_n), 32'd0);
        check("ar_full4", 32'(bus4.full), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ar_after_we",   32'(bus.imem_we), 32'd0);
        check("ar_after_done", 32'(bus.load_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Encoder-side counterpart of the opcode decoder in the control unit.
- Accepts symbolic instructions (mnemonic code plus fields) from a host over a valid/ready handshake and encodes them into 32-bit MIPS machine words.
- Writes the words sequentially into instruction memory from address 0.
- Holds the processor in reset until the program is loaded, then releases it.

Parameters:
- ADDR_W, 6, word-address width of instruction memory.
- DEPTH, 64, number of writable words; must be ≤ 2**ADDR_W and ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  host presents an instruction.
- in_ready  out  1  loader can accept; a transfer happens when in_valid && in_ready at a rising edge.
- in_op  in  4  mnemonic: 0 R-type, 1 lw, 2 sw, 3 beq, 4 addi, 5 andi, 6 j, 7 ori, 8 lui, 9 addiu, 10-15 illegal.
- in_rs  in  5  source register.
- in_rt  in  5  target register.
- in_rd  in  5  destination register (R-type only).
- in_funct  in  6  function field (R-type only).
- in_imm  in  16  immediate / branch offset.
- in_target  in  26  jump target (j only).
- in_last  in  1  marks the final instruction of the program.
- restart  in  1  synchronous request to begin a new load.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- words_loaded  out  ADDR_W+1  count of words written since the last restart.
- load_done  out  1  program loaded.
- full  out  1  DEPTH reached without in_last.
- err  out  1  illegal in_op received.
- cpu_rst_n  out  1  processor reset, active-low; low until load_done.

Behaviour:
- Reset (rst_n low, async): state IDLE.
  - in_ready=1.
  - imem_we=0, imem_addr=0, imem_wdata=0, words_loaded=0.
  - load_done=0, full=0, err=0, cpu_rst_n=0.
- All outputs are registered, except in_ready, which is decoded from state (1 only in IDLE).
- Encoding (opcode[31:26]):
  - R-type: {000000, rs, rt, rd, 5'b0, funct}.
  - I-type: {opc, rs, rt, imm}, with opc = lw 100011, sw 101011, beq 000100, addi 001000, andi 001100, ori 001101, addiu 001001.
  - lui: {001111, 5'b0, rt, imm}; in_rs is ignored.
  - j: {000010, target}.
  - Unused fields for the selected op are ignored.
- IDLE, transfer with a legal op:
  - Latch the encoded word into imem_wdata.
  - Go to WRITE.
- IDLE, transfer with an illegal op:
  - Go to ERR, err=1.
  - No write; words_loaded is unchanged.
- WRITE (exactly one cycle):
  - imem_we=1 with the current imem_addr.
  - Next edge: words_loaded+=1, imem_we=0.
  - If the latched in_last was 1: go to DONE.
  - Else if imem_addr==DEPTH-1: go to DONE with full=1.
  - Else: imem_addr+=1 and go to IDLE.
- Timing:
  - Latency: transfer at edge N; imem_we high in cycle N+1.
  - Maximum throughput: one instruction per 2 cycles.
- DONE:
  - load_done=1, cpu_rst_n=1, in_ready=0.
  - imem_addr holds the last written address.
- ERR:
  - err sticky, cpu_rst_n=0, in_ready=0.
- restart=1 at an edge, from any state:
  - Next state IDLE; imem_addr=0, words_loaded=0.
  - load_done, full, err cleared; cpu_rst_n=0.
  - A write already asserted in WRITE completes in that cycle.
  - A transfer coincident with restart in IDLE is discarded.
- imem_addr never wraps.
- DEPTH=1: the first legal write goes to DONE; full=1 unless in_last.
- in_valid held with no transfer (not IDLE): the host must keep its fields stable; no data is lost.

Test Plan:
- Reset then idle: all outputs at their reset values, in_ready=1, cpu_rst_n=0 → no imem_we for 10 cycles.
- Encoding sequence, each single transfer, check imem_wdata on imem_we:
  - lw rs=29 rt=8 imm=0x0004 → 0x8FA80004 at addr 0.
  - R-type rs=8 rt=9 rd=10 funct=0x20 → 0x01095020 at addr 1.
  - lui rt=1 imm=0x1001 with rs=31 → 0x3C011001.
  - j target=0x0000010 with in_last=1 → 0x08000010; next cycle load_done=1, cpu_rst_n=1, words_loaded=4.
- Back-to-back: in_valid held high for 5 instructions → imem_we pulses every 2 cycles at addrs 0..4; in_ready low in WRITE cycles.
- Full, DEPTH=4: 5 addi transfers, no in_last → 4 writes, full=1, load_done=1; 5th never accepted.
- Illegal in_op=12 after 2 words → err=1, no third write, words_loaded=2, cpu_rst_n=0.
- Recovery: restart → err=0, imem_addr=0, in_ready=1. rst_n pulsed low mid-WRITE → imem_we drops immediately and all outputs reset.
